// File: rtl/dash_pkg.sv
// Shared types and key codes for the dashboard command controller.
package dash_pkg;

  typedef enum logic [1:0] {
    GEAR_P = 2'd0,
    GEAR_R = 2'd1,
    GEAR_N = 2'd2,
    GEAR_D = 2'd3
  } gear_t;

  typedef enum logic {
    FLT_RELEASED = 1'b0,
    FLT_HELD     = 1'b1
  } flt_state_t;

  localparam logic [3:0] KEY_PARK  = 4'd1;
  localparam logic [3:0] KEY_REV   = 4'd2;
  localparam logic [3:0] KEY_NEU   = 4'd3;
  localparam logic [3:0] KEY_LEFT  = 4'd4;
  localparam logic [3:0] KEY_ON    = 4'd5;
  localparam logic [3:0] KEY_RIGHT = 4'd6;
  localparam logic [3:0] KEY_HAZ   = 4'd7;
  localparam logic [3:0] KEY_HEAD  = 4'd8;
  localparam logic [3:0] KEY_DRV   = 4'd10;
  localparam logic [3:0] KEY_MIR_R = 4'd13;
  localparam logic [3:0] KEY_MIR_L = 4'd14;
  localparam logic [3:0] KEY_BRAKE = 4'd15;

  // Map a gear-select key to its gear; callers only pass gear keys.
  function automatic gear_t key_to_gear(input logic [3:0] code);
    case (code)
      KEY_REV: return GEAR_R;
      KEY_NEU: return GEAR_N;
      KEY_DRV: return GEAR_D;
      default: return GEAR_P;
    endcase
  endfunction

endpackage

// File: rtl/dash_cmd_ctrl_key_event_filter.sv
// Turns intermittent per-column scan samples into single press events,
// and keeps a short "brake was recently held" memory because the keypad
// path is single-key: the brake drops out as soon as another key is used.
//
// state        | meaning
// FLT_RELEASED | no key held; next valid sample is a new press
// FLT_HELD     | held_code is down; waiting for RELEASE_CYCLES without a match
module key_event_filter
  import dash_pkg::*;
#(
  parameter int unsigned RELEASE_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_event,
  output logic [3:0] key_event_code,
  output logic       brake_held,
  output logic       brake_recent
);

  localparam int unsigned CW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_CYCLES - 1);

  flt_state_t    state_q;
  logic [3:0]    held_code_q;
  logic [CW-1:0] rel_cnt_q;
  logic          event_q;
  logic [3:0]    event_code_q;
  logic          recent_q, recent_d;
  logic [CW-1:0] brk_cnt_q, brk_cnt_d;

  // Press/release FSM; a matching sample on the deadline cycle keeps the key held
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FLT_RELEASED;
      held_code_q  <= '0;
      rel_cnt_q    <= '0;
      event_q      <= 1'b0;
      event_code_q <= '0;
    end else begin
      event_q <= 1'b0;
      if (state_q == FLT_RELEASED) begin
        if (key_valid) begin
          state_q      <= FLT_HELD;
          held_code_q  <= key_code;
          rel_cnt_q    <= '0;
          event_q      <= 1'b1;
          event_code_q <= key_code;
        end
      end else begin
        if (key_valid && (key_code == held_code_q)) begin
          rel_cnt_q <= '0;
        end else if (rel_cnt_q == REL_LAST) begin
          state_q   <= FLT_RELEASED;
          rel_cnt_q <= '0;
        end else begin
          rel_cnt_q <= rel_cnt_q + 1'b1;
        end
      end
    end
  end

  assign brake_held = (state_q == FLT_HELD) && (held_code_q == KEY_BRAKE);

  // Brake memory tail: restarts while brake is held, expires RELEASE_CYCLES after release
  always_comb begin
    recent_d  = recent_q;
    brk_cnt_d = brk_cnt_q;
    if (brake_held) begin
      recent_d  = 1'b1;
      brk_cnt_d = '0;
    end else if (recent_q) begin
      if (brk_cnt_q == REL_LAST) begin
        recent_d  = 1'b0;
        brk_cnt_d = '0;
      end else begin
        brk_cnt_d = brk_cnt_q + 1'b1;
      end
    end
  end

  // Register the brake memory tail
  always_ff @(posedge clk) begin
    if (rst) begin
      recent_q  <= 1'b0;
      brk_cnt_q <= '0;
    end else begin
      recent_q  <= recent_d;
      brk_cnt_q <= brk_cnt_d;
    end
  end

  assign key_event      = event_q;
  assign key_event_code = event_code_q;
  assign brake_recent   = brake_held | recent_q;

endmodule

// File: rtl/dash_cmd_ctrl.sv
// Dashboard command controller: gear/ignition state, turn/hazard blinker,
// headlights and mirrors, driven by filtered keypad press events.
module dash_cmd_ctrl
  import dash_pkg::*;
#(
  parameter int unsigned RELEASE_CYCLES = 5_000_000,
  parameter int unsigned BLINK_CYCLES   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic [1:0] gear,
  output logic       ignition,
  output logic       lamp_left,
  output logic       lamp_right,
  output logic       headlights,
  output logic       brake_lamp,
  output logic       reverse_lamp,
  output logic       mirror_l,
  output logic       mirror_r,
  output logic       key_event,
  output logic [3:0] key_event_code
);

  localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic       evt;
  logic [3:0] evt_code;
  logic       brake_held;
  logic       brake_recent;

  gear_t      gear_q;
  logic       ign_q, left_q, right_q, haz_q, head_q, mir_l_q, mir_r_q;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic       phase_q, phase_d;
  logic       blink_active;

  key_event_filter #(
    .RELEASE_CYCLES(RELEASE_CYCLES)
  ) u_filter (
    .clk           (clk),
    .rst           (rst),
    .key_code      (key_code),
    .key_valid     (key_valid),
    .key_event     (evt),
    .key_event_code(evt_code),
    .brake_held    (brake_held),
    .brake_recent  (brake_recent)
  );

  // Car state FSM: commands only take effect on the event cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      gear_q  <= GEAR_P;
      ign_q   <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      haz_q   <= 1'b0;
      head_q  <= 1'b0;
      mir_l_q <= 1'b0;
      mir_r_q <= 1'b0;
    end else if (evt) begin
      case (evt_code)
        KEY_ON: begin
          if (!ign_q) begin
            ign_q <= 1'b1;
          end else if (gear_q == GEAR_P) begin
            // Engine off drops driving lights; hazard stays for a parked car
            ign_q   <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            head_q  <= 1'b0;
          end
        end
        KEY_PARK, KEY_REV, KEY_NEU, KEY_DRV: begin
          if (ign_q && brake_recent) gear_q <= key_to_gear(evt_code);
        end
        KEY_LEFT: begin
          if (ign_q) begin
            left_q  <= ~left_q;
            right_q <= 1'b0;
          end
        end
        KEY_RIGHT: begin
          if (ign_q) begin
            right_q <= ~right_q;
            left_q  <= 1'b0;
          end
        end
        KEY_HAZ:   haz_q   <= ~haz_q;
        KEY_HEAD:  if (ign_q) head_q <= ~head_q;
        KEY_MIR_L: mir_l_q <= ~mir_l_q;
        KEY_MIR_R: mir_r_q <= ~mir_r_q;
        default: ;
      endcase
    end
  end

  assign blink_active = left_q | right_q | haz_q;

  // Blinker timebase; parked at count 0 / lamp-on phase while idle so a new request lights at once
  always_comb begin
    blink_cnt_d = '0;
    phase_d     = 1'b1;
    if (blink_active) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
      end
    end
  end

  // Register the blinker timebase
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign gear           = gear_q;
  assign ignition       = ign_q;
  assign lamp_left      = phase_q & (left_q | haz_q);
  assign lamp_right     = phase_q & (right_q | haz_q);
  assign headlights     = head_q;
  assign brake_lamp     = brake_held;
  assign reverse_lamp   = (gear_q == GEAR_R);
  assign mirror_l       = mir_l_q;
  assign mirror_r       = mir_r_q;
  assign key_event      = evt;
  assign key_event_code = evt_code;

endmodule

// File: tb/tb_dash_cmd_ctrl.sv
// Bench for dash_cmd_ctrl with short timeouts (release 8, blink half-period 4).
module tb_dash_cmd_ctrl;

  localparam int R = 8;
  localparam int B = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic [1:0] gear;
  logic       ignition, lamp_left, lamp_right, headlights, brake_lamp;
  logic       reverse_lamp, mirror_l, mirror_r, key_event;
  logic [3:0] key_event_code;

  int checks = 0;
  int errors = 0;
  int ev_count = 0;

  always #5 clk = ~clk;

  dash_cmd_ctrl #(.RELEASE_CYCLES(R), .BLINK_CYCLES(B)) dut (
    .clk           (clk),
    .rst           (rst),
    .key_code      (key_code),
    .key_valid     (key_valid),
    .gear          (gear),
    .ignition      (ignition),
    .lamp_left     (lamp_left),
    .lamp_right    (lamp_right),
    .headlights    (headlights),
    .brake_lamp    (brake_lamp),
    .reverse_lamp  (reverse_lamp),
    .mirror_l      (mirror_l),
    .mirror_r      (mirror_r),
    .key_event     (key_event),
    .key_event_code(key_event_code)
  );

  logic [14:0] dut_vec;
  assign dut_vec = {gear, ignition, lamp_left, lamp_right, headlights, brake_lamp,
                    reverse_lamp, mirror_l, mirror_r, key_event, key_event_code};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (time-stamp based) ----------------
  int         cyc = 0;
  bit         chk_en = 0;
  bit         m_held, m_evt;
  logic [3:0] m_code, m_evcode;
  int         m_last, m_brk_rel, m_act;
  logic [1:0] m_gear;
  bit         m_ign, m_left, m_right, m_haz, m_head, m_ml, m_mr;

  always @(posedge clk) begin : model
    bit old_active, brk_pre, new_evt;
    cyc++;
    if (rst) begin
      m_held = 0; m_evt = 0; m_code = 0; m_evcode = 0; m_last = 0;
      m_brk_rel = -1000; m_act = 0; m_gear = 0;
      m_ign = 0; m_left = 0; m_right = 0; m_haz = 0; m_head = 0; m_ml = 0; m_mr = 0;
      chk_en = 1;
    end else begin
      old_active = m_left | m_right | m_haz;
      // brake counts as recent while held or for R cycles after its release
      brk_pre = (m_held && m_code == 4'd15) || (((cyc - 1) - m_brk_rel) < R);
      if (m_evt) begin
        case (m_evcode)
          4'd5: if (!m_ign) m_ign = 1;
                else if (m_gear == 2'd0) begin m_ign = 0; m_left = 0; m_right = 0; m_head = 0; end
          4'd1:  if (m_ign && brk_pre) m_gear = 2'd0;
          4'd2:  if (m_ign && brk_pre) m_gear = 2'd1;
          4'd3:  if (m_ign && brk_pre) m_gear = 2'd2;
          4'd10: if (m_ign && brk_pre) m_gear = 2'd3;
          4'd4:  if (m_ign) begin m_left = !m_left; m_right = 0; end
          4'd6:  if (m_ign) begin m_right = !m_right; m_left = 0; end
          4'd7:  m_haz = !m_haz;
          4'd8:  if (m_ign) m_head = !m_head;
          4'd14: m_ml = !m_ml;
          4'd13: m_mr = !m_mr;
          default: ;
        endcase
      end
      new_evt = 0;
      if (!m_held) begin
        if (key_valid) begin
          m_held = 1; m_code = key_code; m_last = cyc; new_evt = 1; m_evcode = key_code;
        end
      end else if (key_valid && key_code == m_code) begin
        m_last = cyc;
      end else if (cyc - m_last >= R) begin
        m_held = 0;
        if (m_code == 4'd15) m_brk_rel = cyc;
      end
      m_evt = new_evt;
      if ((m_left | m_right | m_haz) && !old_active) m_act = cyc;
    end
  end

  function automatic logic [14:0] m_expected();
    bit ph;
    ph = (((cyc - m_act) / B) % 2) == 0;
    return {m_gear, m_ign, ph & (m_left | m_haz), ph & (m_right | m_haz), m_head,
            m_held && (m_code == 4'd15), m_gear == 2'd1, m_ml, m_mr, m_evt, m_evcode};
  endfunction

  always @(negedge clk) begin
    if (key_event === 1'b1) ev_count++;
    if (chk_en) check("model", {17'd0, dut_vec}, {17'd0, m_expected()});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sample(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic press(input logic [3:0] c, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      sample(c);
      tick(gap - 1);
    end
    tick(10);
  endtask

  typedef struct {
    logic [3:0] code;
    int         n;
    int         gap;
    logic [1:0] gear;
    bit         ign;
    bit         head;
    bit         ml;
    bit         mr;
  } vec_t;

  vec_t       tbl [17];
  logic [3:0] pool [16];

  initial begin
    int ev0, highs, toggles;
    logic prev;

    tbl[0]  = '{4'd5,  10, 4, 2'd0, 1, 0, 0, 0};
    tbl[1]  = '{4'd2,  3,  2, 2'd0, 1, 0, 0, 0};
    tbl[2]  = '{4'd15, 4,  2, 2'd0, 1, 0, 0, 0};
    tbl[3]  = '{4'd2,  3,  2, 2'd1, 1, 0, 0, 0};
    tbl[4]  = '{4'd15, 4,  2, 2'd1, 1, 0, 0, 0};
    tbl[5]  = '{4'd10, 3,  2, 2'd3, 1, 0, 0, 0};
    tbl[6]  = '{4'd5,  3,  2, 2'd3, 1, 0, 0, 0};
    tbl[7]  = '{4'd8,  3,  2, 2'd3, 1, 1, 0, 0};
    tbl[8]  = '{4'd15, 4,  2, 2'd3, 1, 1, 0, 0};
    tbl[9]  = '{4'd1,  3,  2, 2'd0, 1, 1, 0, 0};
    tbl[10] = '{4'd5,  3,  2, 2'd0, 0, 0, 0, 0};
    tbl[11] = '{4'd14, 3,  2, 2'd0, 0, 0, 1, 0};
    tbl[12] = '{4'd13, 3,  2, 2'd0, 0, 0, 1, 1};
    tbl[13] = '{4'd0,  3,  2, 2'd0, 0, 0, 1, 1};
    tbl[14] = '{4'd8,  3,  2, 2'd0, 0, 0, 1, 1};
    tbl[15] = '{4'd15, 4,  2, 2'd0, 0, 0, 1, 1};
    tbl[16] = '{4'd3,  3,  2, 2'd0, 0, 0, 1, 1};
    pool = '{4'd5, 4'd15, 4'd15, 4'd2, 4'd3, 4'd10, 4'd1, 4'd4,
             4'd6, 4'd7, 4'd8, 4'd13, 4'd14, 4'd0, 4'd9, 4'd5};

    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0;
    tick(3);
    check("reset_outputs", {17'd0, dut_vec}, 32'd0);
    rst = 1'b0;
    tick(2);

    // table-driven key operations
    for (int r = 0; r < 17; r++) begin
      ev0 = ev_count;
      press(tbl[r].code, tbl[r].n, tbl[r].gap);
      check($sformatf("row%0d_events", r), ev_count - ev0, 1);
      check($sformatf("row%0d_evcode", r), key_event_code, tbl[r].code);
      check($sformatf("row%0d_gear", r), gear, tbl[r].gear);
      check($sformatf("row%0d_reverse", r), reverse_lamp, tbl[r].gear == 2'd1);
      check($sformatf("row%0d_ign", r), ignition, tbl[r].ign);
      check($sformatf("row%0d_head", r), headlights, tbl[r].head);
      check($sformatf("row%0d_mirrors", r), {mirror_l, mirror_r}, {tbl[r].ml, tbl[r].mr});
    end

    // left blinker from a fresh start
    press(4'd5, 3, 2);
    sample(4'd4);
    check("event_latency", key_event, 1);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("left_blink%0d", i), lamp_left, ((i / 4) % 2) == 0);
      @(negedge clk);
    end
    tick(10);

    // switch to right: left goes dark, right keeps blinking
    sample(4'd6);
    @(negedge clk);
    highs = 0; toggles = 0; prev = lamp_right;
    for (int i = 0; i < 12; i++) begin
      if (lamp_left) highs++;
      if (lamp_right != prev) toggles++;
      prev = lamp_right;
      @(negedge clk);
    end
    check("left_dark_after_right", highs, 0);
    check("right_toggles", toggles >= 2, 1);
    tick(10);

    // ignition off clears turn signal; hazard works without ignition
    press(4'd5, 3, 2);
    check("ign_off_for_hazard", ignition, 0);
    check("right_cleared", lamp_right, 0);
    sample(4'd7);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("haz_left%0d", i), lamp_left, ((i / 4) % 2) == 0);
      check($sformatf("haz_inphase%0d", i), lamp_right, lamp_left);
      @(negedge clk);
    end
    tick(2);

    // second key while one is held is ignored
    ev0 = ev_count;
    for (int i = 0; i < 6; i++) begin
      sample(4'd8);
      sample(4'd14);
    end
    tick(10);
    check("held_single_event", ev_count - ev0, 1);
    check("held_evcode", key_event_code, 8);
    check("held_mirror_l", mirror_l, 1);
    press(4'd14, 3, 2);
    check("mirror_l_after_release", mirror_l, 0);

    // reset while a key is held and still sampled
    key_valid = 1'b1; key_code = 4'd5;
    tick(2);
    rst = 1'b1;
    @(negedge clk);
    check("midpress_reset", {17'd0, dut_vec}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_event", key_event, 1);
    check("post_reset_evcode", key_event_code, 5);
    key_valid = 1'b0;
    tick(12);

    // randomized key traffic against the model
    for (int k = 0; k < 150; k++) begin
      logic [3:0] c;
      int n, gap;
      if ($urandom_range(0, 30) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      c   = pool[$urandom_range(0, 15)];
      n   = $urandom_range(1, 5);
      gap = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) begin
        key_valid = 1'b1;
        key_code  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : c;
        @(negedge clk);
        key_valid = 1'b0;
        tick(gap - 1);
      end
      tick($urandom_range(0, 14));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
